// File: rtl/noc_traffic_node.sv
// NoC test endpoint: generates PKT_NUM multi-flit packets towards one destination
// and reassembles/checks every packet it receives, one checker FSM per virtual channel.
`ifndef Noc_Data_Width
`define Noc_Data_Width 64
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Axi_LEN_Bit
`define Axi_LEN_Bit 8
`endif
`ifndef Noc_Marker_Width
`define Noc_Marker_Width 4
`endif
`ifndef Noc_Type_Width
`define Noc_Type_Width 2
`endif
`ifndef Noc_Order_Width
`define Noc_Order_Width 4
`endif
`ifndef Noc_Head_H
`define Noc_Head_H 4'hC
`endif
`ifndef Noc_Head_E
`define Noc_Head_E 4'h3
`endif
`ifndef Noc_Tail_H
`define Noc_Tail_H 4'hE
`endif
`ifndef Noc_Tail_E
`define Noc_Tail_E 4'h7
`endif

module noc_traffic_node #(
  parameter logic [`Noc_ID_X_Width-1:0] X_ID      = '0,
  parameter logic [`Noc_ID_Y_Width-1:0] Y_ID      = '0,
  parameter logic [`Noc_ID_X_Width-1:0] DEST_X_ID = '0,
  parameter logic [`Noc_ID_Y_Width-1:0] DEST_Y_ID = '0,
  parameter int unsigned PKT_NUM    = 16,
  parameter int unsigned DATA_FLITS = 1,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned VC_NUM     = 1
) (
  input  logic                       noc_clk,
  input  logic                       noc_rst_n,
  input  logic                       start,
  input  logic                       rx_stall,
  input  logic [VC_NUM-1:0]          receive_valid,
  output logic [VC_NUM-1:0]          receive_ready,
  input  logic [`Noc_Data_Width-1:0] receive_flit,
  input  logic                       receive_is_header,
  input  logic                       receive_is_tail,
  output logic [VC_NUM-1:0]          sender_valid,
  input  logic [VC_NUM-1:0]          sender_ready,
  output logic [`Noc_Data_Width-1:0] sender_flit,
  output logic                       sender_is_header,
  output logic                       sender_is_tail,
  output logic [15:0]                tx_pkt_cnt,
  output logic [15:0]                rx_pkt_cnt,
  output logic [15:0]                rx_err_cnt,
  output logic                       tx_done
);

  localparam int DW      = `Noc_Data_Width;
  localparam int MW      = `Noc_Marker_Width;
  localparam int ID_W    = `Noc_ID_X_Width + `Noc_ID_Y_Width;
  localparam int TW      = `Noc_Type_Width;
  localparam int OW      = `Noc_Order_Width;
  localparam int LW      = `Axi_LEN_Bit;
  localparam int PAD_W   = DW - (2 * MW + 2 * ID_W + TW + OW + LW);
  localparam int SRC_LSB = DW - MW - ID_W;
  localparam int DST_LSB = SRC_LSB - ID_W;
  localparam int LEN_LSB = PAD_W + MW;
  localparam int E_LSB   = PAD_W;

  localparam logic [15:0] LAST_SEQ = 16'(PKT_NUM - 1);
  localparam logic [7:0]  LAST_IDX = 8'(DATA_FLITS - 1);
  localparam logic [7:0]  LAST_GAP = 8'(GAP_CYCLES - 1);
  localparam logic [1:0]  LAST_VC  = 2'(VC_NUM - 1);

  function automatic logic [DW-1:0] mk_ctrl(input logic [MW-1:0] h, input logic [MW-1:0] e,
                                            input logic [15:0] seq);
    mk_ctrl = {h, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID, {TW{1'b0}}, seq[OW-1:0],
               LW'(DATA_FLITS), e, {PAD_W{1'b0}}};
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [15:0] seq, input logic [7:0] k);
    mk_data = DW'({seq[7:0], k});
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [VC_NUM-1:0] vc_onehot(input logic [1:0] vc);
    vc_onehot = '0;
    for (int v = 0; v < VC_NUM; v++) vc_onehot[v] = (vc == 2'(v));
  endfunction

  // ---------------- sender ----------------
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_TAIL, S_GAP, S_DONE} snd_state_t;

  snd_state_t        snd_state_q, snd_state_d;
  logic [15:0]       seq_q, seq_d, tx_cnt_q, tx_cnt_d;
  logic [1:0]        vc_q, vc_d, vc_next;
  logic [7:0]        idx_q, idx_d, gap_q, gap_d;
  logic              done_q, done_d, hdr_q, hdr_d, tail_q, tail_d;
  logic [VC_NUM-1:0] valid_q, valid_d;
  logic [DW-1:0]     flit_q, flit_d;
  logic              accepted;

  assign accepted = |(valid_q & sender_ready);
  assign vc_next  = (vc_q == LAST_VC) ? 2'd0 : vc_q + 2'd1;

  always_comb begin
    snd_state_d = snd_state_q;
    seq_d       = seq_q;
    vc_d        = vc_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    tx_cnt_d    = tx_cnt_q;
    done_d      = done_q;
    valid_d     = valid_q;
    flit_d      = flit_q;
    hdr_d       = hdr_q;
    tail_d      = tail_q;
    case (snd_state_q)
      S_IDLE: if (start) begin
        if (PKT_NUM == 0) begin
          snd_state_d = S_DONE;
          done_d      = 1'b1;
        end else begin
          snd_state_d = S_HEADER;
          seq_d       = '0;
          vc_d        = '0;
          valid_d     = vc_onehot(2'd0);
          flit_d      = mk_ctrl(`Noc_Head_H, `Noc_Head_E, 16'd0);
          hdr_d       = 1'b1;
          tail_d      = 1'b0;
        end
      end
      S_HEADER: if (accepted) begin
        snd_state_d = S_DATA;
        idx_d       = '0;
        flit_d      = mk_data(seq_q, 8'd0);
        hdr_d       = 1'b0;
      end
      S_DATA: if (accepted) begin
        if (idx_q == LAST_IDX) begin
          snd_state_d = S_TAIL;
          flit_d      = mk_ctrl(`Noc_Tail_H, `Noc_Tail_E, seq_q);
          tail_d      = 1'b1;
        end else begin
          idx_d  = idx_q + 8'd1;
          flit_d = mk_data(seq_q, idx_q + 8'd1);
        end
      end
      S_TAIL: if (accepted) begin
        tx_cnt_d = sat_inc(tx_cnt_q);
        tail_d   = 1'b0;
        valid_d  = '0;
        flit_d   = '0;
        if (seq_q == LAST_SEQ) begin
          snd_state_d = S_DONE;
          done_d      = 1'b1;
        end else begin
          seq_d = seq_q + 16'd1;
          vc_d  = vc_next;
          if (GAP_CYCLES == 0) begin
            snd_state_d = S_HEADER;
            valid_d     = vc_onehot(vc_next);
            flit_d      = mk_ctrl(`Noc_Head_H, `Noc_Head_E, seq_q + 16'd1);
            hdr_d       = 1'b1;
          end else begin
            snd_state_d = S_GAP;
            gap_d       = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_q == LAST_GAP) begin
          snd_state_d = S_HEADER;
          valid_d     = vc_onehot(vc_q);
          flit_d      = mk_ctrl(`Noc_Head_H, `Noc_Head_E, seq_q);
          hdr_d       = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      S_DONE: begin
        valid_d = '0;
        done_d  = 1'b1;
      end
      default: snd_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      snd_state_q <= S_IDLE;
      seq_q       <= '0;
      vc_q        <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      tx_cnt_q    <= '0;
      done_q      <= 1'b0;
      valid_q     <= '0;
      flit_q      <= '0;
      hdr_q       <= 1'b0;
      tail_q      <= 1'b0;
    end else begin
      snd_state_q <= snd_state_d;
      seq_q       <= seq_d;
      vc_q        <= vc_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      tx_cnt_q    <= tx_cnt_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      flit_q      <= flit_d;
      hdr_q       <= hdr_d;
      tail_q      <= tail_d;
    end
  end

  assign sender_valid     = valid_q;
  assign sender_flit      = flit_q;
  assign sender_is_header = hdr_q;
  assign sender_is_tail   = tail_q;
  assign tx_pkt_cnt       = tx_cnt_q;
  assign tx_done          = done_q;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {R_WAIT_HDR, R_DATA, R_TAIL, R_DISCARD} rcv_state_t;

  rcv_state_t        rx_state_q [VC_NUM];
  rcv_state_t        rx_state_d [VC_NUM];
  logic [ID_W-1:0]   src_q [VC_NUM];
  logic [ID_W-1:0]   src_d [VC_NUM];
  logic [7:0]        len_q [VC_NUM];
  logic [7:0]        len_d [VC_NUM];
  logic [7:0]        ridx_q [VC_NUM];
  logic [7:0]        ridx_d [VC_NUM];
  logic [VC_NUM-1:0] rdy_q, take;
  logic [15:0]       rx_cnt_q, err_cnt_q;
  logic              pkt_inc, err_inc;

  logic [MW-1:0]   f_h, f_e;
  logic [ID_W-1:0] f_src, f_dst;
  logic [7:0]      f_len, f_idx;

  assign f_h   = receive_flit[DW-1 -: MW];
  assign f_e   = receive_flit[E_LSB +: MW];
  assign f_src = receive_flit[SRC_LSB +: ID_W];
  assign f_dst = receive_flit[DST_LSB +: ID_W];
  assign f_len = 8'(receive_flit[LEN_LSB +: LW]);
  assign f_idx = receive_flit[7:0];
  assign take  = receive_valid & rdy_q;

  always_comb begin
    rx_state_d = rx_state_q;
    src_d      = src_q;
    len_d      = len_q;
    ridx_d     = ridx_q;
    pkt_inc    = 1'b0;
    err_inc    = 1'b0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (take[v]) begin
        case (rx_state_q[v])
          R_WAIT_HDR: begin
            if (receive_is_header && f_h == `Noc_Head_H && f_e == `Noc_Head_E &&
                f_dst == {X_ID, Y_ID}) begin
              src_d[v]      = f_src;
              len_d[v]      = f_len;
              ridx_d[v]     = '0;
              rx_state_d[v] = (f_len == 8'd0) ? R_TAIL : R_DATA;
            end else begin
              err_inc = 1'b1;
              if (!receive_is_tail) rx_state_d[v] = R_DISCARD;
            end
          end
          R_DATA: begin
            if (f_idx == ridx_q[v] && !receive_is_header && !receive_is_tail) begin
              ridx_d[v] = ridx_q[v] + 8'd1;
              if (ridx_q[v] == len_q[v] - 8'd1) rx_state_d[v] = R_TAIL;
            end else begin
              err_inc       = 1'b1;
              rx_state_d[v] = receive_is_tail ? R_WAIT_HDR : R_DISCARD;
            end
          end
          R_TAIL: begin
            if (receive_is_tail && f_h == `Noc_Tail_H && f_e == `Noc_Tail_E && f_src == src_q[v])
              pkt_inc = 1'b1;
            else
              err_inc = 1'b1;
            rx_state_d[v] = R_WAIT_HDR;
          end
          R_DISCARD: if (receive_is_tail) rx_state_d[v] = R_WAIT_HDR;
          default: rx_state_d[v] = R_WAIT_HDR;
        endcase
      end
    end
  end

  // ready is a registered copy of ~rx_stall, so a stall takes effect one cycle late
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int v = 0; v < VC_NUM; v++) begin
        rx_state_q[v] <= R_WAIT_HDR;
        src_q[v]      <= '0;
        len_q[v]      <= '0;
        ridx_q[v]     <= '0;
      end
      rdy_q     <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      src_q      <= src_d;
      len_q      <= len_d;
      ridx_q     <= ridx_d;
      rdy_q      <= {VC_NUM{~rx_stall}};
      if (pkt_inc) rx_cnt_q <= sat_inc(rx_cnt_q);
      if (err_inc) err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign receive_ready = rdy_q;
  assign rx_pkt_cnt    = rx_cnt_q;
  assign rx_err_cnt    = err_cnt_q;

endmodule

// File: doc/noc_traffic_node.md
# noc_traffic_node

Parametrised NoC test endpoint that generates a configurable stream of multi-flit packets towards one destination and checks every packet it receives. It is used in mesh-level benches as the local port of each router, replacing the fixed 3-flit single-channel test node. It adds a true valid/ready handshake, per-virtual-channel reassembly, payload checking and status counters.

## Interface
- X_ID, 0: own X coordinate, `Noc_ID_X_Width bits.
- Y_ID, 0: own Y coordinate, `Noc_ID_Y_Width bits.
- DEST_X_ID, 0: destination X coordinate.
- DEST_Y_ID, 0: destination Y coordinate.
- PKT_NUM, 16: packets to send, 0..65535; 0 means send nothing.
- DATA_FLITS, 1: data flits per packet, 1..255; must fit in `Axi_LEN_Bit.
- GAP_CYCLES, 0: idle cycles after each tail is accepted, 0..255.
- VC_NUM, 1: virtual channels, 1..4.

Ports:
- noc_clk  in  1  clock.
- noc_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level; the sender leaves IDLE while high.
- rx_stall  in  1  forces all receive_ready low.
- receive_valid  in  VC_NUM  per-VC flit valid; at most one bit set per cycle.
- receive_ready  out  VC_NUM  per-VC ready.
- receive_flit  in  `Noc_Data_Width  shared flit bus.
- receive_is_header / receive_is_tail  in  1  flit-type qualifiers.
- sender_valid  out  VC_NUM  one-hot flit valid.
- sender_ready  in  VC_NUM  per-VC ready from the router.
- sender_flit  out  `Noc_Data_Width  flit.
- sender_is_header / sender_is_tail  out  1  flit-type qualifiers.
- tx_pkt_cnt / rx_pkt_cnt / rx_err_cnt  out  16  counters; they saturate at 16'hFFFF.
- tx_done  out  1  high once PKT_NUM packets have been sent.

## Operation
- Transfer rule: a flit moves when sender_valid[v] & sender_ready[v] are both high.
  - While a flit is waiting, valid, flit and the qualifiers stay stable.
  - The same rule applies on the receive side.
- Header flit: {`Noc_Head_H, X_ID, Y_ID, DEST_X_ID, DEST_Y_ID, TYPE=0, PACK_ORDER=seq low bits, LEN=DATA_FLITS, `Noc_Head_E, zeros}.
- Tail flit: same layout with `Noc_Tail_H / `Noc_Tail_E.
- Data flit k (k = 0..DATA_FLITS-1): low 16 bits are {seq[7:0], k[7:0]}; all upper bits are 0.
- seq is the packet number, 0..PKT_NUM-1. Packet p uses VC (p mod VC_NUM) for all its flits.
- Sender states:
  - IDLE -> HEADER when start=1. If PKT_NUM=0, IDLE -> DONE instead.
  - HEADER -> DATA when the header is accepted.
  - DATA stays until data flit DATA_FLITS-1 is accepted, then -> TAIL.
  - TAIL -> GAP on acceptance, or directly to HEADER when GAP_CYCLES=0; tx_pkt_cnt increments.
  - After the last packet, TAIL -> DONE.
  - GAP counts GAP_CYCLES cycles, then -> HEADER.
  - DONE is terminal until reset: tx_done=1, sender_valid=0.
  - Dropping start mid-packet has no effect; start is sampled only in IDLE.
- Receiver keeps one reassembly FSM per VC (WAIT_HDR, DATA, TAIL, DISCARD) with per-VC stored src ID, len and index. Flits of different VCs may interleave.
- WAIT_HDR accepts only a flit with is_header=1, matching H/E markers and dest == {X_ID, Y_ID}.
  - On success: store src and len, go to DATA.
  - On failure: rx_err_cnt+1; a non-tail flit -> DISCARD, a tail flit stays in WAIT_HDR.
- DATA: the low byte must equal the expected index, and is_header and is_tail must both be 0; the index increments.
  - After len data flits -> TAIL.
  - Mismatch: err+1 -> DISCARD; if the bad flit has is_tail=1, -> WAIT_HDR instead.
- TAIL: requires is_tail=1, tail markers, and src equal to the stored src.
  - On success: rx_pkt_cnt+1.
  - On failure: err+1.
  - Either way -> WAIT_HDR.
- DISCARD drops flits until a flit with is_tail=1, then -> WAIT_HDR. No further error counts are added while in DISCARD.
- receive_ready = {VC_NUM{~rx_stall}}, registered from rx_stall: ready drops one cycle after rx_stall rises.

## Timing
- Reset values: sender_valid=0, sender_flit=0, both sender qualifiers 0, receive_ready=0, all counters 0, tx_done=0; all FSMs in IDLE / WAIT_HDR.
- receive_ready goes to all-ones on the first clock after reset release when rx_stall=0.
- All outputs are registered.
- Sender latency:
  - The header appears on the first edge after start is sampled high in IDLE.
  - With ready held high, flits go out back-to-back: 1 + DATA_FLITS + 1 cycles per packet, plus GAP_CYCLES.
- The counter updates the cycle after the tail is accepted; tx_done asserts the same cycle tx_pkt_cnt reaches PKT_NUM.
- Asserting reset mid-packet clears everything immediately. The next packet starts from seq 0.

## Test plan
- Loopback of sender to receiver, VC_NUM=1, DATA_FLITS=4, PKT_NUM=3, ready tied high -> 18 valid cycles, rx_pkt_cnt=3, rx_err_cnt=0, tx_done=1.
- Random sender_ready toggling (~50%) with PKT_NUM=10 -> flit stable while waiting, no flit lost, rx_pkt_cnt=10.
- VC_NUM=2 with flits of two packets interleaved on the receive bus -> both packets counted, err=0.
- Injected header with wrong dest, followed by 2 data flits and a tail -> rx_err_cnt=1, rx_pkt_cnt unchanged; the next good packet is counted.
- Data index skipped (0,2) in a 3-data-flit packet -> err=1, DISCARD until the tail, then recovery.
- Reset asserted mid-DATA, then start -> outputs zero during reset; the next header carries PACK_ORDER=0 and tx_pkt_cnt=0.
